// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RV32 pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // A real register dependency: x0 is hard-wired to zero and never matches.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

  // Operand source for one EX operand; the younger MEM result wins over WB.
  function automatic fwd_e fwd_sel(input logic [4:0] rs,
                                   input logic [4:0] rd_mem, input logic we_mem,
                                   input logic [4:0] rd_wb,  input logic we_wb);
    fwd_e sel;
    if (we_mem && reg_match(rd_mem, rs)) begin
      sel = FWD_MEM;
    end else if (we_wb && reg_match(rd_wb, rs)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_ctrl.sv
// Data-memory wait tracker: freezes the pipeline while an access is pending
// and halts the core for good when an access hangs for TIMEOUT wait cycles.
module mem_wait_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_mem_req_MEM,
  input  logic i_mem_ready,
  output logic o_freeze,
  output logic o_halted
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Next-state and wait counter; ready in the last wait cycle beats the timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (i_mem_req_MEM && !i_mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          state_d    = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // An illegal encoding is treated as a fault: stop the core.
        state_d = ST_HALT;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Freeze decode: a fresh miss freezes already in its first MEM cycle.
  always_comb begin
    case (state_q)
      ST_RUN:      o_freeze = i_mem_req_MEM && !i_mem_ready;
      ST_MEM_WAIT: o_freeze = !i_mem_ready;
      ST_HALT:     o_freeze = 1'b1;
      default:     o_freeze = 1'b1;
    endcase
  end

  assign o_halted = (state_q == ST_HALT);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage RV32 core: EX operand
// forwarding, load-use bubbles, branch redirect flushes and memory freeze.
// Optional macro HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [4:0] i_rs1_ID,
  input  logic [4:0] i_rs2_ID,
  input  logic [4:0] i_rs1_EX,
  input  logic [4:0] i_rs2_EX,
  input  logic [4:0] i_rd_EX,
  input  logic [1:0] i_result_src_EX,
  input  logic       i_pc_src_EX,
  input  logic [4:0] i_rd_MEM,
  input  logic       i_reg_write_MEM,
  input  logic [4:0] i_rd_WB,
  input  logic       i_reg_write_WB,
  input  logic       i_mem_req_MEM,
  input  logic       i_mem_ready,
  output logic       o_stall_IF,
  output logic       o_stall_ID,
  output logic       o_stall_EX,
  output logic       o_stall_MEM,
  output logic       o_flush_ID,
  output logic       o_flush_EX,
  output logic [1:0] o_fwd_a_EX,
  output logic [1:0] o_fwd_b_EX,
`ifdef HAZARD_PERF_EN
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt,
`endif
  output logic       o_halted
);

  logic freeze;
  logic load_use;

  mem_wait_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait_ctrl (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_mem_req_MEM (i_mem_req_MEM),
    .i_mem_ready   (i_mem_ready),
    .o_freeze      (freeze),
    .o_halted      (o_halted)
  );

  assign load_use = (i_result_src_EX == RESULT_SRC_LOAD) &&
                    (reg_match(i_rd_EX, i_rs1_ID) || reg_match(i_rd_EX, i_rs2_ID));

  // Stall/flush priority: freeze, then redirect (ID is wrong-path), then load-use.
  always_comb begin
    o_stall_IF  = 1'b0;
    o_stall_ID  = 1'b0;
    o_stall_EX  = 1'b0;
    o_stall_MEM = 1'b0;
    o_flush_ID  = 1'b0;
    o_flush_EX  = 1'b0;
    if (freeze) begin
      o_stall_IF  = 1'b1;
      o_stall_ID  = 1'b1;
      o_stall_EX  = 1'b1;
      o_stall_MEM = 1'b1;
    end else if (i_pc_src_EX) begin
      o_flush_ID  = 1'b1;
      o_flush_EX  = 1'b1;
    end else if (load_use) begin
      o_stall_IF  = 1'b1;
      o_stall_ID  = 1'b1;
      o_flush_EX  = 1'b1;
    end else begin
      o_flush_EX  = 1'b0;
    end
  end

  // Forwarding selects, independent of freeze.
  always_comb begin
    o_fwd_a_EX = fwd_sel(i_rs1_EX, i_rd_MEM, i_reg_write_MEM, i_rd_WB, i_reg_write_WB);
    o_fwd_b_EX = fwd_sel(i_rs2_EX, i_rd_MEM, i_reg_write_MEM, i_rd_WB, i_reg_write_WB);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, o_stall_IF};
    flush_cnt_d = flush_cnt_q + {31'd0, o_flush_ID};
  end

  // Counter registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RV32 core. Generates forwarding selects for the EX stage, stall enables and synchronous flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers, and freezes the whole pipeline while data memory is not ready. A watchdog halts the core on a hung memory access.

## Interface
Parameters:
- TIMEOUT, 256, maximum MEM_WAIT cycles before halt (≥2)

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rs1_ID, i_rs2_ID  in  5  source registers of instruction in ID
- i_rs1_EX, i_rs2_EX  in  5  source registers in EX
- i_rd_EX  in  5  destination in EX
- i_result_src_EX  in  2  result select in EX; 2'b01 = load
- i_pc_src_EX  in  1  taken branch or jump resolved in EX
- i_rd_MEM, i_reg_write_MEM  in  5/1  destination and write enable in MEM
- i_rd_WB, i_reg_write_WB  in  5/1  destination and write enable in WB
- i_mem_req_MEM  in  1  load/store present in MEM
- i_mem_ready  in  1  data memory completes access this cycle
- o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM  out  1  hold stage register (enable low)
- o_flush_ID, o_flush_EX  out  1  synchronous clear of IF/ID, ID/EX
- o_fwd_a_EX, o_fwd_b_EX  out  2  operand select: 00 regfile, 01 WB, 10 MEM
- o_halted  out  1  sticky memory-timeout halt

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Counter wait_cnt, width $clog2(TIMEOUT).
- freeze = (RUN & i_mem_req_MEM & !i_mem_ready) | (MEM_WAIT & !i_mem_ready) | HALT.
- RUN -> MEM_WAIT when i_mem_req_MEM & !i_mem_ready; wait_cnt <= 0.
- MEM_WAIT -> RUN when i_mem_ready; else wait_cnt++; when wait_cnt == TIMEOUT-1 and !i_mem_ready -> HALT.
- HALT: absorbing until reset; o_halted = 1.
- freeze: all four stalls = 1, both flushes = 0; overrides every other rule.
- load_use = i_result_src_EX==2'b01 & i_rd_EX!=0 & (i_rd_EX==i_rs1_ID | i_rd_EX==i_rs2_ID).
- Not frozen, i_pc_src_EX: o_flush_ID = o_flush_EX = 1, no stalls; redirect beats load_use (ID instruction is wrong-path).
- Not frozen, load_use, !i_pc_src_EX: o_stall_IF = o_stall_ID = 1, o_flush_EX = 1 (bubble).
- Forwarding (per operand, rs = i_rs1_EX / i_rs2_EX): 10 if i_reg_write_MEM & i_rd_MEM!=0 & i_rd_MEM==rs; else 01 if i_reg_write_WB & i_rd_WB!=0 & i_rd_WB==rs; else 00. MEM priority over WB. Forwarding is independent of freeze.
- x0 never forwarded, never causes load-use.

## Timing
- Stalls, flushes, forwards: combinational from inputs and current state, same cycle.
- Reset (async): state RUN, wait_cnt 0, o_halted 0, perf counters 0; with idle inputs all outputs 0.
- Access ready on first MEM cycle: no freeze, no MEM_WAIT entry.
- Access taking N cycles (N ≤ TIMEOUT): freeze for N-1 cycles, released the cycle i_mem_ready rises.
- Timeout: HALT entered on the edge after the TIMEOUT-th cycle without ready; i_mem_ready arriving in that same cycle wins (-> RUN).
- Reset mid-MEM_WAIT or HALT: immediate return to RUN, freeze released asynchronously.

## Configuration
- HAZARD_PERF_EN defined: adds outputs o_stall_cnt[31:0] (cycles with o_stall_IF = 1) and o_flush_cnt[31:0] (cycles with o_flush_ID = 1); free-running, wrap at 2^32, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- hazard_pkg: state enum (ST_RUN, ST_MEM_WAIT, ST_HALT), forward enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), RESULT_SRC_LOAD = 2'b01.
- Sub-module mem_wait_ctrl: FSM, wait_cnt, freeze and o_halted; top holds load-use, redirect and forwarding logic.

## Test plan
- EX load rd=5, ID add rs1=5 -> stall_IF=stall_ID=flush_EX=1 for one cycle; next cycle fwd_a_EX=01 or 10 per stage.
- MEM rd=3 write, WB rd=3 write, EX rs2=3 -> fwd_b_EX=10; MEM rd=0 -> 01 from WB; both rd=0 -> 00.
- Load-use plus i_pc_src_EX=1 same cycle -> flush_ID=flush_EX=1, stall_IF=0.
- i_mem_req_MEM=1, ready after 4 cycles -> all stalls high 3 cycles, flushes 0, back to RUN; with PERF, o_stall_cnt=3.
- TIMEOUT=8, ready never -> HALT after 8 wait cycles, o_halted=1, stalls stuck high; assert i_rst_n=0 -> all clear immediately.
- Ready asserted exactly at cycle TIMEOUT -> RUN, o_halted stays 0.
